// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA MPU interfaces.
// The MPU read interface uses the VGA_READ_AUTOINC_EN configuration macro.
package vga_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 17;
  localparam int unsigned VRAM_DATA_WIDTH = 8;
  localparam int unsigned MPU_SYNC_STAGES = 2;

  typedef logic [VRAM_ADDR_WIDTH-1:0] vramAddress_t;

  typedef enum logic [2:0] {
    REG_ADDR_LO  = 3'd0,
    REG_ADDR_MID = 3'd1,
    REG_ADDR_HI  = 3'd2,
    REG_DATA     = 3'd3,
    REG_STATUS   = 3'd4
  } regSelect_t;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_ACTIVE
  } fetchState_t;

  localparam int unsigned STATUS_BUSY     = 0;
  localparam int unsigned STATUS_VALID    = 1;
  localparam int unsigned STATUS_UNDERRUN = 2;

endpackage

// File: rtl/mpu_select_sync.sv
// Synchronizes the asynchronous MPU chipSelect and emits a one-clock pulse on its rising edge.
module mpu_select_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetN,
  input  logic chipSelect,
  output logic selectRise
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], chipSelect};
      prevQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign selectRise = syncQ[SYNC_STAGES-1] & ~prevQ;

endmodule

// File: rtl/mpu_read_interface.sv
// MPU read-back path from VRAM: address registers, request/ack fetch FSM, readable data register.
// VGA_READ_AUTOINC_EN: data-register reads post-increment the address and prefetch the next byte.
module mpu_read_interface
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = VRAM_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = MPU_SYNC_STAGES
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  chipSelect,
  input  logic                  writeEnable,
  input  logic [2:0]            registerSelect,
  input  logic [DATA_WIDTH-1:0] registerDataIn,
  output logic [DATA_WIDTH-1:0] registerDataOut,
  output logic                  registerDataOutEnable,
  output logic                  memReadRequest,
  output logic [ADDR_WIDTH-1:0] memReadAddress,
  input  logic                  memReadAck,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  logic selectRise;

  mpu_select_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_selectSync (
    .clock     (clock),
    .resetN    (resetN),
    .chipSelect(chipSelect),
    .selectRise(selectRise)
  );

  logic [ADDR_WIDTH-1:0] addressQ, addressD;
  logic [ADDR_WIDTH-1:0] reqAddrQ, reqAddrD;
  logic [DATA_WIDTH-1:0] dataRegQ, dataRegD;
  logic                  validQ, validD;
  logic                  underrunQ, underrunD;
  logic                  restartQ, restartD;
  fetchState_t           stateQ, stateD;
  logic                  fetchStart;
  logic                  addrWrite;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      addressQ  <= '0;
      reqAddrQ  <= '0;
      dataRegQ  <= '0;
      validQ    <= 1'b0;
      underrunQ <= 1'b0;
      restartQ  <= 1'b0;
      stateQ    <= FETCH_IDLE;
    end else begin
      addressQ  <= addressD;
      reqAddrQ  <= reqAddrD;
      dataRegQ  <= dataRegD;
      validQ    <= validD;
      underrunQ <= underrunD;
      restartQ  <= restartD;
      stateQ    <= stateD;
    end
  end

  always_comb begin
    addressD   = addressQ;
    reqAddrD   = reqAddrQ;
    dataRegD   = dataRegQ;
    validD     = validQ;
    underrunD  = underrunQ;
    restartD   = restartQ;
    stateD     = stateQ;
    fetchStart = 1'b0;
    addrWrite  = 1'b0;

    // One bus action per MPU cycle, taken on the synchronized chipSelect edge.
    if (selectRise) begin
      if (writeEnable) begin
        case (regSelect_t'(registerSelect))
          REG_ADDR_LO: begin
            addressD[7:0] = registerDataIn;
            addrWrite     = 1'b1;
          end
          REG_ADDR_MID: begin
            addressD[15:8] = registerDataIn;
            addrWrite      = 1'b1;
          end
          REG_ADDR_HI: begin
            addressD[16] = registerDataIn[0];
            addrWrite    = 1'b1;
            fetchStart   = 1'b1;
          end
          default: ;
        endcase
      end else if (regSelect_t'(registerSelect) == REG_DATA) begin
        if (!validQ) begin
          underrunD = 1'b1;
        end
`ifdef VGA_READ_AUTOINC_EN
        else begin
          addressD   = addressQ + ADDR_WIDTH'(1);
          fetchStart = 1'b1;
        end
`endif
      end
    end

    if (addrWrite) begin
      underrunD = 1'b0;
    end
    if (fetchStart) begin
      validD = 1'b0;
    end

    case (stateQ)
      FETCH_IDLE: begin
        if (fetchStart) begin
          stateD   = FETCH_ACTIVE;
          reqAddrD = addressD;
          restartD = 1'b0;
        end
      end
      FETCH_ACTIVE: begin
        if (memReadAck) begin
          if (restartQ || addrWrite) begin
            // Address moved under the in-flight fetch: drop the byte and refetch.
            reqAddrD = addressD;
            restartD = 1'b0;
          end else begin
            dataRegD = memReadData;
            validD   = 1'b1;
            stateD   = FETCH_IDLE;
          end
        end else if (addrWrite) begin
          restartD = 1'b1;
        end
      end
      default: stateD = FETCH_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] statusByte;

  always_comb begin
    statusByte                  = '0;
    statusByte[STATUS_BUSY]     = (stateQ == FETCH_ACTIVE);
    statusByte[STATUS_VALID]    = validQ;
    statusByte[STATUS_UNDERRUN] = underrunQ;

    case (regSelect_t'(registerSelect))
      REG_ADDR_LO:  registerDataOut = addressQ[7:0];
      REG_ADDR_MID: registerDataOut = addressQ[15:8];
      REG_ADDR_HI:  registerDataOut = {{(DATA_WIDTH-1){1'b0}}, addressQ[16]};
      REG_DATA:     registerDataOut = dataRegQ;
      REG_STATUS:   registerDataOut = statusByte;
      default:      registerDataOut = '0;
    endcase
  end

  assign registerDataOutEnable = chipSelect & ~writeEnable;
  assign memReadRequest        = (stateQ == FETCH_ACTIVE);
  assign memReadAddress        = reqAddrQ;

endmodule

// File: tb/tb_mpu_read_interface.sv
// Scoreboard bench for mpu_read_interface; expectations follow VGA_READ_AUTOINC_EN when defined.
module tb_mpu_read_interface;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        chipSelect = 1'b0;
  logic        writeEnable = 1'b0;
  logic [2:0]  registerSelect = 3'd0;
  logic [7:0]  registerDataIn = 8'd0;
  logic [7:0]  registerDataOut;
  logic        registerDataOutEnable;
  logic        memReadRequest;
  logic [16:0] memReadAddress;
  logic        memReadAck = 1'b0;
  logic [7:0]  memReadData = 8'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } readExp_t;

  readExp_t    expQ[$];
  logic [16:0] reqQ[$];

  always #5 clock = ~clock;

  mpu_read_interface dut (
    .clock                (clock),
    .resetN               (resetN),
    .chipSelect           (chipSelect),
    .writeEnable          (writeEnable),
    .registerSelect       (registerSelect),
    .registerDataIn       (registerDataIn),
    .registerDataOut      (registerDataOut),
    .registerDataOutEnable(registerDataOutEnable),
    .memReadRequest       (memReadRequest),
    .memReadAddress       (memReadAddress),
    .memReadAck           (memReadAck),
    .memReadData          (memReadData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitor: compares MPU read data and new VRAM requests against the queues.
  logic        prevOe = 1'b0;
  logic        prevReq = 1'b0;
  logic [16:0] prevAddr = '0;

  always @(negedge clock) begin
    readExp_t e;
    logic [16:0] a;
    if (resetN) begin
      if (registerDataOutEnable && !prevOe) begin
        if (expQ.size() == 0) begin
          check("unexpectedRead", {24'd0, registerDataOut}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          check(e.tag, {24'd0, registerDataOut}, {24'd0, e.value});
        end
      end
      if (memReadRequest && (!prevReq || memReadAddress != prevAddr)) begin
        if (reqQ.size() == 0) begin
          check("unexpectedRequest", {15'd0, memReadAddress}, 32'hFFFF_FFFF);
        end else begin
          a = reqQ.pop_front();
          check("requestAddress", {15'd0, memReadAddress}, {15'd0, a});
        end
      end
    end
    prevOe   = registerDataOutEnable;
    prevReq  = memReadRequest;
    prevAddr = memReadAddress;
  end

  task automatic busCycle(input logic we, input logic [2:0] sel, input logic [7:0] data);
    @(posedge clock);
    #1;
    writeEnable    = we;
    registerSelect = sel;
    registerDataIn = data;
    chipSelect     = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chipSelect = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  task automatic mpuWrite(input logic [2:0] sel, input logic [7:0] data);
    busCycle(1'b1, sel, data);
  endtask

  task automatic mpuRead(input string tag, input logic [2:0] sel, input logic [7:0] want);
    readExp_t e;
    e.tag   = tag;
    e.value = want;
    expQ.push_back(e);
    busCycle(1'b0, sel, 8'h00);
  endtask

  task automatic ackWith(input logic [7:0] data, input int delay);
    repeat (delay) @(posedge clock);
    #1;
    memReadAck  = 1'b1;
    memReadData = data;
    @(posedge clock);
    #1;
    memReadAck = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] staleByte;
    logic [7:0] lastByte;

    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (2) @(posedge clock);

    // Reset state.
    check("resetRequest", {31'd0, memReadRequest}, 32'd0);
    mpuRead("resetStatus", 3'd4, 8'h00);
    mpuRead("resetData", 3'd3, 8'h00);
    mpuRead("resetAddrLo", 3'd0, 8'h00);
    mpuRead("underrunStatus", 3'd4, 8'h04);

    // Basic fetch.
    mpuWrite(3'd0, 8'h34);
    mpuWrite(3'd1, 8'h12);
    reqQ.push_back(17'h11234);
    mpuWrite(3'd2, 8'h01);
    mpuRead("busyStatus", 3'd4, 8'h01);
    ackWith(8'hA5, 5);
    mpuRead("validStatus", 3'd4, 8'h02);
    mpuRead("addrHi", 3'd2, 8'h01);
`ifdef VGA_READ_AUTOINC_EN
    reqQ.push_back(17'h11235);
    mpuRead("fetchedData", 3'd3, 8'hA5);
    ackWith(8'h5A, 3);
    mpuRead("autoincAddrLo", 3'd0, 8'h35);
`else
    mpuRead("fetchedData", 3'd3, 8'hA5);
    mpuRead("keepAddrLo", 3'd0, 8'h34);
    mpuRead("keepValid", 3'd4, 8'h02);
`endif

    // Increment wrap at the top of VRAM.
    mpuWrite(3'd0, 8'hFF);
    mpuWrite(3'd1, 8'hFF);
    reqQ.push_back(17'h1FFFF);
    mpuWrite(3'd2, 8'h01);
    ackWith(8'h3C, 2);
`ifdef VGA_READ_AUTOINC_EN
    reqQ.push_back(17'h00000);
    mpuRead("topData", 3'd3, 8'h3C);
    mpuRead("prefetchBusy", 3'd4, 8'h01);
    ackWith(8'h11, 2);
    mpuRead("wrapAddrLo", 3'd0, 8'h00);
    mpuRead("wrapAddrHi", 3'd2, 8'h00);
    staleByte = 8'h11;
`else
    mpuRead("topData", 3'd3, 8'h3C);
    mpuRead("noFetchStatus", 3'd4, 8'h02);
    mpuRead("noWrapAddrLo", 3'd0, 8'hFF);
    mpuRead("noWrapAddrHi", 3'd2, 8'h01);
    staleByte = 8'h3C;
`endif

    // Read while busy, then address write clears underrun and restarts the fetch.
    mpuWrite(3'd0, 8'h10);
    mpuWrite(3'd1, 8'h00);
    reqQ.push_back(17'h00010);
    mpuWrite(3'd2, 8'h00);
    mpuRead("staleData", 3'd3, staleByte);
    mpuRead("busyUnderrun", 3'd4, 8'h05);
    mpuWrite(3'd0, 8'h20);
    mpuRead("underrunCleared", 3'd4, 8'h01);
    reqQ.push_back(17'h00020);
    ackWith(8'h77, 1);
    mpuRead("restartBusy", 3'd4, 8'h01);
    ackWith(8'h99, 2);
    mpuRead("restartDone", 3'd4, 8'h02);

    // High-byte write during fetch discards the in-flight byte.
    mpuWrite(3'd0, 8'h40);
    reqQ.push_back(17'h10040);
    mpuWrite(3'd2, 8'h01);
    mpuWrite(3'd2, 8'h00);
    reqQ.push_back(17'h00040);
    ackWith(8'h77, 1);
    mpuRead("discardStatus", 3'd4, 8'h01);
    ackWith(8'h88, 2);
    mpuRead("refetchStatus", 3'd4, 8'h02);
`ifdef VGA_READ_AUTOINC_EN
    reqQ.push_back(17'h00041);
    mpuRead("refetchData", 3'd3, 8'h88);
    ackWith(8'h42, 2);
    lastByte = 8'h42;
`else
    mpuRead("refetchData", 3'd3, 8'h88);
    lastByte = 8'h88;
`endif

    // Stray ack while idle.
    ackWith(8'hEE, 2);
    mpuRead("strayStatus", 3'd4, 8'h02);
`ifdef VGA_READ_AUTOINC_EN
    reqQ.push_back(17'h00042);
    mpuRead("strayData", 3'd3, lastByte);
    ackWith(8'h00, 2);
`else
    mpuRead("strayData", 3'd3, lastByte);
`endif

    // Reset in the middle of a fetch.
    mpuWrite(3'd0, 8'h55);
    reqQ.push_back(17'h10055);
    mpuWrite(3'd2, 8'h01);
    check("midFetchRequest", {31'd0, memReadRequest}, 32'd1);
    @(negedge clock);
    #1 resetN = 1'b0;
    #1 check("asyncResetRequest", {31'd0, memReadRequest}, 32'd0);
    @(posedge clock);
    #1 resetN = 1'b1;
    repeat (2) @(posedge clock);
    check("postResetRequest", {31'd0, memReadRequest}, 32'd0);
    mpuRead("postResetStatus", 3'd4, 8'h00);
    mpuRead("postResetAddrLo", 3'd0, 8'h00);
    mpuRead("postResetAddrHi", 3'd2, 8'h00);
    mpuRead("postResetData", 3'd3, 8'h00);

    repeat (10) @(posedge clock);
    check("pendingReads", expQ.size(), 32'd0);
    check("pendingRequests", reqQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
